// File: rtl/hall_call_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hall_call_dispatcher: latches hall calls, picks them round-robin and      |
// | offers each one to the nearer ready car of two.           Rev 1.0         |
// +--------------------------------------------------------------------------+
module hall_call_dispatcher #(
    parameter int FLOORS = 8,
    parameter int POS_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] hall_req,
    input  logic [POS_W-1:0]  car0_pos,
    input  logic [POS_W-1:0]  car1_pos,
    input  logic              car0_rdy,
    input  logic              car1_rdy,
    output logic              car0_vld,
    output logic              car1_vld,
    output logic [POS_W-1:0]  car0_tgt,
    output logic [POS_W-1:0]  car1_tgt,
    output logic [FLOORS-1:0] pending,
    output logic [7:0]        dispatch_cnt
);

    localparam logic [POS_W-1:0]  c_last_floor = POS_W'(FLOORS - 1);
    localparam logic [FLOORS-1:0] c_one_hot0   = FLOORS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PICK   = 2'd1,
        ST_ASSIGN = 2'd2,
        ST_OFFER  = 2'd3
    } state_t;

    state_t            r_state;
    logic [FLOORS-1:0] r_pending;
    logic [POS_W-1:0]  r_rr_ptr;
    logic [POS_W-1:0]  r_sel_floor;
    logic              r_chosen_car1;
    logic              r_car0_vld;
    logic              r_car1_vld;
    logic [POS_W-1:0]  r_car0_tgt;
    logic [POS_W-1:0]  r_car1_tgt;
    logic [7:0]        r_dispatch_cnt;

    logic              w_pick_found;
    logic [POS_W-1:0]  w_pick_floor;
    logic              w_pick_car1;
    logic              w_handshake;
    logic [FLOORS-1:0] w_clr_mask;
    logic [POS_W-1:0]  w_rr_next;

    // Round-robin scan: first pending floor at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        j            = 0;
        w_pick_found = 1'b0;
        w_pick_floor = '0;
        for (int i = 0; i < FLOORS; i++) begin
            j = int'(r_rr_ptr) + i;
            if (j >= FLOORS) begin
                j = j - FLOORS;
            end
            if (!w_pick_found && r_pending[j]) begin
                w_pick_found = 1'b1;
                w_pick_floor = POS_W'(j);
            end
        end
    end

    // Positions beyond the top floor count as the top floor for distance.
    always_comb begin
        int p0, p1, s, d0, d1;
        p0 = int'(car0_pos);
        p1 = int'(car1_pos);
        s  = int'(r_sel_floor);
        if (p0 > FLOORS - 1) p0 = FLOORS - 1;
        if (p1 > FLOORS - 1) p1 = FLOORS - 1;
        d0 = (p0 > s) ? (p0 - s) : (s - p0);
        d1 = (p1 > s) ? (p1 - s) : (s - p1);
        if (car0_rdy && car1_rdy) begin
            w_pick_car1 = (d1 < d0);
        end else begin
            w_pick_car1 = car1_rdy;
        end
    end

    assign w_handshake = (r_state == ST_OFFER) &&
                         (r_chosen_car1 ? (r_car1_vld && car1_rdy) : (r_car0_vld && car0_rdy));
    assign w_clr_mask  = w_handshake ? (c_one_hot0 << r_sel_floor) : '0;
    assign w_rr_next   = (r_sel_floor == c_last_floor) ? '0 : r_sel_floor + POS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_sel_floor    <= '0;
            r_chosen_car1  <= 1'b0;
            r_car0_vld     <= 1'b0;
            r_car1_vld     <= 1'b0;
            r_car0_tgt     <= '0;
            r_car1_tgt     <= '0;
            r_dispatch_cnt <= '0;
        end else begin
            // A new call on the floor being cleared wins over the clear.
            r_pending <= (r_pending & ~w_clr_mask) | hall_req;
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_state <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (w_pick_found) begin
                        r_sel_floor <= w_pick_floor;
                        r_state     <= ST_ASSIGN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ASSIGN: begin
                    if (car0_rdy || car1_rdy) begin
                        r_chosen_car1 <= w_pick_car1;
                        if (w_pick_car1) begin
                            r_car1_vld <= 1'b1;
                            r_car1_tgt <= r_sel_floor;
                        end else begin
                            r_car0_vld <= 1'b1;
                            r_car0_tgt <= r_sel_floor;
                        end
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_handshake) begin
                        r_car0_vld     <= 1'b0;
                        r_car1_vld     <= 1'b0;
                        r_car0_tgt     <= '0;
                        r_car1_tgt     <= '0;
                        r_rr_ptr       <= w_rr_next;
                        r_dispatch_cnt <= r_dispatch_cnt + 8'd1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign car0_vld     = r_car0_vld;
    assign car1_vld     = r_car1_vld;
    assign car0_tgt     = r_car0_tgt;
    assign car1_tgt     = r_car1_tgt;
    assign pending      = r_pending;
    assign dispatch_cnt = r_dispatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hall_call_dispatcher: directed scenarios for hall_call_dispatcher.    |
// |                                                           Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_hall_call_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] hall_req;
    logic [2:0] car0_pos, car1_pos;
    logic       car0_rdy, car1_rdy;
    logic       car0_vld, car1_vld;
    logic [2:0] car0_tgt, car1_tgt;
    logic [7:0] pending;
    logic [7:0] dispatch_cnt;

    int n_vec = 0;
    int n_err = 0;

    hall_call_dispatcher #(.FLOORS(8), .POS_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hall_req     (hall_req),
        .car0_pos     (car0_pos),
        .car1_pos     (car1_pos),
        .car0_rdy     (car0_rdy),
        .car1_rdy     (car1_rdy),
        .car0_vld     (car0_vld),
        .car1_vld     (car1_vld),
        .car0_tgt     (car0_tgt),
        .car1_tgt     (car1_tgt),
        .pending      (pending),
        .dispatch_cnt (dispatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits a bounded number of edges for any offer; reports floor and car.
    task automatic wait_offer(output logic found, output logic [2:0] floor, output logic car1);
        found = 1'b0;
        floor = '0;
        car1  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (car0_vld || car1_vld) begin
                found = 1'b1;
                car1  = car1_vld;
                floor = car1_vld ? car1_tgt : car0_tgt;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hall_req = '0;
        car0_pos = '0; car1_pos = '0; car0_rdy = 1'b1; car1_rdy = 1'b1;
        #2;
        n_vec++;
        if ({car0_vld, car1_vld, car0_tgt, car1_tgt, pending, dispatch_cnt} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_state: got vld=%b%b tgt=%0d/%0d pend=%h cnt=%0d required all 0",
                     car0_vld, car1_vld, car0_tgt, car1_tgt, pending, dispatch_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        car0_pos = 3'd0; car1_pos = 3'd0; car0_rdy = 1'b1; car1_rdy = 1'b1;
        hall_req = 8'h08; tick(); hall_req = '0;
        n_vec++;
        if (pending !== 8'h08) begin n_err++; $display("FAIL basic_pending_set: got %h required 08", pending); end
        tick(); tick();
        n_vec++;
        if (car0_vld !== 1'b0 || car1_vld !== 1'b0) begin
            n_err++; $display("FAIL basic_early_vld: got %b%b required 00", car0_vld, car1_vld);
        end
        tick();
        n_vec++;
        if ({car0_vld, car0_tgt, car1_vld, car1_tgt} !== {1'b1, 3'd3, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL basic_offer: got v0=%b t0=%0d v1=%b t1=%0d required v0=1 t0=3 v1=0 t1=0",
                              car0_vld, car0_tgt, car1_vld, car1_tgt);
        end
        tick();
        n_vec++;
        if ({pending, dispatch_cnt, car0_vld, car0_tgt} !== {8'h00, 8'd1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL basic_handshake: got pend=%h cnt=%0d v0=%b t0=%0d required 00 1 0 0",
                              pending, dispatch_cnt, car0_vld, car0_tgt);
        end
    endtask

    task automatic test_distance();
        logic f; logic [2:0] fl; logic c1;
        car0_pos = 3'd0; car1_pos = 3'd6;
        hall_req = 8'h20; tick(); hall_req = '0;
        wait_offer(f, fl, c1);
        n_vec++;
        if ({f, c1, fl, car0_vld} !== {1'b1, 1'b1, 3'd5, 1'b0}) begin
            n_err++; $display("FAIL dist_near_car1: got found=%b car1=%b tgt=%0d v0=%b required 1 1 5 0",
                              f, c1, fl, car0_vld);
        end
        tick();
        n_vec++;
        if (dispatch_cnt !== 8'd2) begin n_err++; $display("FAIL dist_cnt: got %0d required 2", dispatch_cnt); end
        car0_pos = 3'd2; car1_pos = 3'd6;
        hall_req = 8'h10; tick(); hall_req = '0;
        wait_offer(f, fl, c1);
        n_vec++;
        if ({f, c1, fl, car1_vld} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
            n_err++; $display("FAIL dist_tie_car0: got found=%b car1=%b tgt=%0d v1=%b required 1 0 4 0",
                              f, c1, fl, car1_vld);
        end
        tick();
    endtask

    task automatic test_rr_order();
        logic f; logic [2:0] fl; logic c1;
        logic [2:0] exp_fl [4] = '{3'd2, 3'd5, 3'd6, 3'd1};
        do_reset();
        car0_pos = 3'd0; car1_pos = 3'd0; car0_rdy = 1'b1; car1_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin hall_req = 8'h24; tick(); hall_req = '0; end
            if (k == 2) begin hall_req = 8'h42; tick(); hall_req = '0; end
            wait_offer(f, fl, c1);
            n_vec++;
            if (f !== 1'b1 || fl !== exp_fl[k]) begin
                n_err++; $display("FAIL rr_order[%0d]: got found=%b tgt=%0d required found=1 tgt=%0d",
                                  k, f, fl, exp_fl[k]);
            end
            tick();
        end
        n_vec++;
        if (dispatch_cnt !== 8'd4) begin n_err++; $display("FAIL rr_cnt: got %0d required 4", dispatch_cnt); end
    endtask

    task automatic test_assign_wait();
        logic f; logic [2:0] fl; logic c1;
        logic seen;
        do_reset();
        car0_pos = 3'd0; car1_pos = 3'd7; car0_rdy = 1'b0; car1_rdy = 1'b0;
        hall_req = 8'h10; tick(); hall_req = '0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | car0_vld | car1_vld;
        end
        hall_req = 8'h02; tick(); hall_req = '0;
        seen = seen | car0_vld | car1_vld;
        n_vec++;
        if (seen !== 1'b0 || pending !== 8'h12) begin
            n_err++; $display("FAIL wait_no_vld: got seen=%b pend=%h required 0 12", seen, pending);
        end
        car1_rdy = 1'b1;
        tick();
        n_vec++;
        if ({car1_vld, car1_tgt, car0_vld} !== {1'b1, 3'd4, 1'b0}) begin
            n_err++; $display("FAIL wait_offer_car1: got v1=%b t1=%0d v0=%b required 1 4 0",
                              car1_vld, car1_tgt, car0_vld);
        end
        tick();
        n_vec++;
        if ({pending, dispatch_cnt, car1_vld} !== {8'h02, 8'd1, 1'b0}) begin
            n_err++; $display("FAIL wait_handshake: got pend=%h cnt=%0d v1=%b required 02 1 0",
                              pending, dispatch_cnt, car1_vld);
        end
        wait_offer(f, fl, c1);
        n_vec++;
        if ({f, c1, fl} !== {1'b1, 1'b1, 3'd1}) begin
            n_err++; $display("FAIL wait_second: got found=%b car1=%b tgt=%0d required 1 1 1", f, c1, fl);
        end
        tick();
        car0_rdy = 1'b1;
    endtask

    task automatic test_set_wins();
        logic f; logic [2:0] fl; logic c1;
        do_reset();
        car0_pos = 3'd0; car1_pos = 3'd0; car0_rdy = 1'b1; car1_rdy = 1'b1;
        hall_req = 8'h08; tick(); hall_req = '0;
        tick(); tick(); tick();
        n_vec++;
        if (car0_vld !== 1'b1) begin n_err++; $display("FAIL setwin_offer: got v0=%b required 1", car0_vld); end
        hall_req = 8'h08; tick(); hall_req = '0;
        n_vec++;
        if ({pending, dispatch_cnt, car0_vld} !== {8'h08, 8'd1, 1'b0}) begin
            n_err++; $display("FAIL setwin_pending: got pend=%h cnt=%0d v0=%b required 08 1 0",
                              pending, dispatch_cnt, car0_vld);
        end
        wait_offer(f, fl, c1);
        tick();
        n_vec++;
        if ({f, fl, dispatch_cnt, pending} !== {1'b1, 3'd3, 8'd2, 8'h00}) begin
            n_err++; $display("FAIL setwin_second: got found=%b tgt=%0d cnt=%0d pend=%h required 1 3 2 00",
                              f, fl, dispatch_cnt, pending);
        end
    endtask

    task automatic test_reset_mid_offer();
        logic f; logic [2:0] fl; logic c1;
        hall_req = 8'h42; tick(); hall_req = '0;
        wait_offer(f, fl, c1);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (f !== 1'b1 || {car0_vld, car1_vld, car0_tgt, car1_tgt, pending, dispatch_cnt} !== 24'h0) begin
            n_err++; $display("FAIL midoffer_reset: got found=%b vld=%b%b tgt=%0d/%0d pend=%h cnt=%0d required 1 and all 0",
                              f, car0_vld, car1_vld, car0_tgt, car1_tgt, pending, dispatch_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        hall_req = 8'h04; tick(); hall_req = '0;
        wait_offer(f, fl, c1);
        tick();
        n_vec++;
        if ({f, c1, fl, dispatch_cnt} !== {1'b1, 1'b0, 3'd2, 8'd1}) begin
            n_err++; $display("FAIL midoffer_resume: got found=%b car1=%b tgt=%0d cnt=%0d required 1 0 2 1",
                              f, c1, fl, dispatch_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        logic f; logic [2:0] fl; logic c1;
        int timeouts;
        do_reset();
        timeouts = 0;
        for (int k = 0; k < 256; k++) begin
            hall_req = 8'h01; tick(); hall_req = '0;
            wait_offer(f, fl, c1);
            if (!f) timeouts++;
            tick();
            if (k == 254) begin
                n_vec++;
                if (dispatch_cnt !== 8'd255) begin
                    n_err++; $display("FAIL cnt_255: got %0d required 255", dispatch_cnt);
                end
            end
        end
        n_vec++;
        if (dispatch_cnt !== 8'd0 || timeouts != 0) begin
            n_err++; $display("FAIL cnt_wrap: got cnt=%0d timeouts=%0d required 0 0", dispatch_cnt, timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_distance();
        test_rr_order();
        test_assign_wait();
        test_set_wins();
        test_reset_mid_offer();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hall_call_dispatcher.md
HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

Interface
REQ-001 Parameter FLOORS, default 8, number of floors (one request bit per floor).
REQ-002 Parameter POS_W, default 3, floor-index width; SHALL satisfy 2**POS_W >= FLOORS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hall_req  input  FLOORS  per-floor call pulses; bit f high at a rising edge registers a call at floor f.
REQ-006 car0_pos, car1_pos  input  POS_W each  current floor of car 0 / car 1.
REQ-007 car0_rdy, car1_rdy  input  1 each  car idle and able to accept a target.
REQ-008 car0_vld, car1_vld  output  1 each  target offer to car 0 / car 1.
REQ-009 car0_tgt, car1_tgt  output  POS_W each  offered target floor.
REQ-010 pending  output  FLOORS  registered unserved calls.
REQ-011 dispatch_cnt  output  8  count of completed dispatches.

Function
REQ-012 Each pending[f] SHALL be set at the edge where hall_req[f]=1; repeat calls to an already-pending floor SHALL NOT create a second entry.
REQ-013 The FSM SHALL have states IDLE, PICK, ASSIGN and OFFER.
REQ-014 IDLE: if pending != 0 at an edge, the FSM SHALL go to PICK; otherwise it stays in IDLE.
REQ-015 PICK: the FSM SHALL latch sel_floor and go to ASSIGN; sel_floor is the first set pending bit found scanning upward from rr_ptr, wrapping FLOORS-1 -> 0.
REQ-016 ASSIGN: the car is chosen by sampling car0_rdy/car1_rdy.
- Neither ready: SHALL stay in ASSIGN.
- Exactly one ready: SHALL choose it.
- Both ready: SHALL choose the car with the smaller |pos - sel_floor|; on a tie, car 0.
- The choice SHALL be latched and the FSM SHALL go to OFFER.
REQ-017 OFFER: exactly the chosen car's vld SHALL be 1, with its tgt = sel_floor held stable until handshake.
REQ-018 Handshake SHALL complete at the edge where the chosen car's vld=1 and rdy=1.
REQ-019 At that handshake edge:
- pending[sel_floor] SHALL clear.
- rr_ptr SHALL become (sel_floor+1) mod FLOORS.
- dispatch_cnt SHALL increment, wrapping 255 -> 0.
- The FSM SHALL return to IDLE.
REQ-020 If hall_req[sel_floor]=1 at the handshake edge, set SHALL win: pending[sel_floor] remains 1 as a new call.
REQ-021 The non-chosen car's vld SHALL be 0 at all times; both vld SHALL be 0 outside OFFER.
REQ-022 In OFFER, a pending bit of sel_floor cannot be re-picked until the handshake; other floors' calls SHALL keep accumulating.
REQ-023 Latency from a call into an empty IDLE block with a ready car SHALL be:
- pending set at edge k;
- PICK at k+1;
- ASSIGN at k+2;
- vld high after edge k+3;
- earliest handshake at edge k+4.
REQ-024 tgt outputs SHALL be 0 whenever the corresponding vld is 0.
REQ-025 Bits of hall_req at index >= FLOORS (when FLOORS < 2**POS_W for tgt) SHALL NOT exist; car positions >= FLOORS SHALL be treated as FLOORS-1 for distance.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force:
- FSM = IDLE, pending = 0, rr_ptr = 0, dispatch_cnt = 0;
- car0_vld = car1_vld = 0, car0_tgt = car1_tgt = 0.
REQ-027 Reset asserted during OFFER SHALL drop vld without a handshake and discard all pending calls; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-028 Both cars rdy at floor 0, pulse hall_req[3] -> car0_vld=1, car0_tgt=3 after 4th edge; handshake -> pending=0, dispatch_cnt=1.
REQ-029 car0_pos=0, car1_pos=6, both rdy, call floor 5 -> car1_vld=1, car1_tgt=5; car0_vld stays 0.
REQ-030 Calls at floors 2 and 5 in one pulse, rr_ptr=0 -> dispatch order 2 then 5; next calls 1 and 6 with rr_ptr=6 -> order 6 then 1 (wrap).
REQ-031 Both rdy=0, call floor 4 -> FSM waits in ASSIGN, no vld; car1_rdy=1 -> car1_tgt=4 offered.
REQ-032 Re-pulse hall_req[sel_floor] on the handshake edge -> pending bit stays 1, floor dispatched a second time, dispatch_cnt=2.
REQ-033 Assert rst_n=0 mid-OFFER (no clk edge) -> vld, pending, dispatch_cnt read 0 immediately.
